adf_prog: RTL and testbench
===========================

# adf_prog

Parametrised programmable frequency divider for the DPLL feedback path. Divides `dco_clk` by a ratio derived from the measured input-period word `fin_w`, producing a 50 %-duty `fout`. Adds enable/hold, synchronous phase realignment, saturation of oversize ratios, and glitch-free ratio updates applied only at half-period boundaries.

## Interface

Parameters:
- `IN_W`, 16, width of `fin_w`.
- `SHIFT`, 2, right-shift applied to `fin_w` to form the half-period count H.
- `CNT_W`, 14, counter and `half_act` width; 1 ≤ `CNT_W` ≤ `IN_W`-`SHIFT`.

Ports:
- `dco_clk`  in  1  DCO clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fin_w`  in  `IN_W`  period word from the phase detector; may change on any cycle.
- `en`  in  1  count enable; low freezes the divider.
- `sync`  in  1  synchronous phase realign request, one-cycle pulse.
- `fout`  out  1  divided clock, registered.
- `fout_rise`  out  1  one-cycle pulse, high in the same cycle `fout` goes 0→1.
- `half_act`  out  `CNT_W`  half-period count currently in use.

## Operation

- H = `fin_w` >> `SHIFT`, saturated to 2^`CNT_W`-1 when wider.
- Two states: LOAD and RUN. Reset enters LOAD.
- LOAD:
  - `en` high: `half_act` ← H, `cnt` ← 0, go RUN; no toggle.
  - `en` low: hold.
- RUN, `en` low: `cnt`, `fout` and `half_act` hold; `fout_rise` = 0.
- RUN, `en` high, `cnt` ≥ `half_act`: `cnt` ← 0, `fout` toggles, `half_act` ← H (boundary reload).
- RUN, `en` high, otherwise: `cnt` ← `cnt`+1.
- `sync` (any state, overrides `en` and terminal count): `cnt` ← 0, `fout` ← 0, `fout_rise` ← 0, go LOAD.
- H = 0: `fout` toggles every enabled cycle (divide-by-2).
- Mid-half-period changes of `fin_w` do not affect the current half-period. The comparison uses `half_act` only, never live `fin_w`.
- `cnt` never exceeds `half_act`, so no wrap-around is possible.

## Timing

- Reset values: `fout` = 0, `fout_rise` = 0, `half_act` = 0, `cnt` = 0, state = LOAD.
- Reset deassertion mid-run restarts from LOAD. The first `fout` rise occurs H+1 enabled cycles after the LOAD cycle.
- Each half-period is `half_act`+1 enabled cycles; full period is 2·(H+1) cycles at constant H.
- A new H takes effect at the next toggle edge. Each half-period uses one value; the two halves of a period may differ.
- `fout_rise` coincides with the register update of `fout`, so it is visible one edge after the terminal-count cycle.
- `sync` takes priority over the terminal-count toggle in the same cycle. The cycle after `sync` is in LOAD.
- `en` deasserted on a terminal-count cycle: no toggle; the toggle fires on the first re-enabled cycle.

## Structure

- Shared package `adf_pkg`:
  - state enum `adf_state_t` {LOAD, RUN}.
  - function `adf_sat_half(fin_w)` implementing shift plus saturation.
  - default parameter constants.
- Single module with no sub-module. Saturation is the package function; counter, state and toggle logic sit in one always block per register group.

## Test plan

- Reset, `en`=1, `fin_w`=16 (H=4): first `fout` rise 5 cycles after the LOAD cycle, then period 10 cycles. `fout_rise` high one cycle per period. `half_act`=4.
- `fin_w` changed 16→40 mid-half-period: the current half stays 5 cycles, the next half is 11 cycles. No runt pulse on `fout`.
- `fin_w`=0 and `fin_w`=3 (H=0): `fout` toggles every cycle, period 2.
- `CNT_W`=8, `fin_w`=0xFFFF: `half_act`=255, half-period 256 cycles.
- `en` low for 7 cycles mid-half-period, including over a terminal count: `fout` and `cnt` frozen, and the period stretches by exactly 7 cycles.
- `sync` pulse coincident with terminal count: `fout`=0 next cycle, no `fout_rise`, LOAD state. The next rise is H+1 cycles after the LOAD cycle. Async `rst_n` pulse mid-run restores all reset values immediately.

Source files
------------

// File: rtl/adf_prog_pkg.sv
// Shared definitions for the adf_prog programmable divider.
// Contents:
//   adf_state_t   - divider control state {LOAD, RUN}
//   ADF_*_DEF     - default parameter values for adf_prog
//   adf_sat_half  - forms the half-period count from the period word
//                   (right shift, then saturation to the counter range)
package adf_pkg;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        RUN  = 1'b1
    } adf_state_t;

    localparam int unsigned ADF_IN_W_DEF  = 16;
    localparam int unsigned ADF_SHIFT_DEF = 2;
    localparam int unsigned ADF_CNT_W_DEF = 14;

    // Works on a 32-bit container so one function serves every parameter set;
    // the caller narrows the result to its counter width.
    function automatic logic [31:0] adf_sat_half(input logic [31:0] fin_w,
                                                 input int unsigned shift,
                                                 input int unsigned cnt_w);
        logic [31:0] shifted;
        logic [31:0] limit;
        shifted = fin_w >> shift;
        limit   = (32'd1 << cnt_w) - 32'd1;
        if (shifted > limit) begin
            return limit;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/adf_prog.sv
// adf_prog - programmable 50 %-duty divider for the DPLL feedback path.
// Divides dco_clk by 2*(H+1), where H = fin_w >> SHIFT saturated to CNT_W bits.
// The half-period count in use (half_act) is only reloaded at a toggle edge,
// so changes of fin_w never shorten or stretch the half-period in progress.
// Ports:
//   dco_clk   in   1      only clock
//   rst_n     in   1      asynchronous active-low reset
//   fin_w     in   IN_W   measured period word, may change any cycle
//   en        in   1      count enable; low freezes counter, fout, half_act
//   sync      in   1      one-cycle realign pulse; forces fout low, back to LOAD
//   fout      out  1      divided clock, registered
//   fout_rise out  1      high in the cycle fout has just gone 0->1
//   half_act  out  CNT_W  half-period count currently in use
module adf_prog
    import adf_pkg::*;
#(
    parameter int unsigned IN_W  = ADF_IN_W_DEF,
    parameter int unsigned SHIFT = ADF_SHIFT_DEF,
    parameter int unsigned CNT_W = ADF_CNT_W_DEF
) (
    input  logic             dco_clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  fin_w,
    input  logic             en,
    input  logic             sync,
    output logic             fout,
    output logic             fout_rise,
    output logic [CNT_W-1:0] half_act
);

    adf_state_t       r_state;
    adf_state_t       w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] w_half_nx;
    logic             r_fout;
    logic             w_fout_nx;
    logic             r_rise;
    logic             w_rise_nx;
    logic [CNT_W-1:0] w_h;

    // Candidate half-period count from the live period word; sampled into
    // r_half only on LOAD or at a toggle edge.
    assign w_h = CNT_W'(adf_sat_half(32'(fin_w), SHIFT, CNT_W));

    // Next-state and next-output decode; sync outranks enable and terminal count.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_half_nx  = r_half;
        w_fout_nx  = r_fout;
        w_rise_nx  = 1'b0;
        if (sync) begin
            w_state_nx = LOAD;
            w_cnt_nx   = {CNT_W{1'b0}};
            w_fout_nx  = 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (en) begin
                        w_half_nx  = w_h;
                        w_cnt_nx   = {CNT_W{1'b0}};
                        w_state_nx = RUN;
                    end else begin
                        w_state_nx = LOAD;
                    end
                end
                RUN: begin
                    if (en) begin
                        // ">=" rather than "==" keeps the counter from ever
                        // running past half_act, so it cannot wrap.
                        if (r_cnt >= r_half) begin
                            w_cnt_nx  = {CNT_W{1'b0}};
                            w_fout_nx = ~r_fout;
                            w_rise_nx = ~r_fout;
                            w_half_nx = w_h;
                        end else begin
                            w_cnt_nx = r_cnt + CNT_W'(1'b1);
                        end
                    end else begin
                        w_state_nx = RUN;
                    end
                end
                default: begin
                    w_state_nx = LOAD;
                    w_cnt_nx   = {CNT_W{1'b0}};
                    w_fout_nx  = 1'b0;
                end
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Half-period counter.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else begin
            r_cnt <= w_cnt_nx;
        end
    end

    // Divided clock and its rising-edge marker, updated together.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fout <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_fout <= w_fout_nx;
            r_rise <= w_rise_nx;
        end
    end

    // Active half-period count.
    always_ff @(posedge dco_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_half <= {CNT_W{1'b0}};
        end else begin
            r_half <= w_half_nx;
        end
    end

    assign fout      = r_fout;
    assign fout_rise = r_rise;
    assign half_act  = r_half;

endmodule

// File: tb/tb_adf_prog.sv
// Scoreboard bench for adf_prog. Stimulus pushes the hand-computed cycle of
// every expected fout rise (and the half_act value at that rise) into a
// queue; a monitor pops one entry per observed fout_rise pulse. Cycle numbers
// count dco_clk rising edges; observation happens on falling edges.
// Unit A uses the default parameters, unit B uses CNT_W = 8 with fin_w = 0xFFFF.
module tb_adf_prog;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] fin_w;
    logic        en;
    logic        sync;
    logic        fout;
    logic        fout_rise;
    logic [13:0] half_act;

    logic        b_rst_n;
    logic [15:0] b_fin_w;
    logic        b_en;
    logic        b_sync;
    logic        b_fout;
    logic        b_fout_rise;
    logic [7:0]  b_half_act;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int c     = 0;

    typedef struct {
        int cy;
        int half;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    adf_prog #(.IN_W(16), .SHIFT(2), .CNT_W(14)) u_dut_a (
        .dco_clk   (clk),
        .rst_n     (rst_n),
        .fin_w     (fin_w),
        .en        (en),
        .sync      (sync),
        .fout      (fout),
        .fout_rise (fout_rise),
        .half_act  (half_act)
    );

    adf_prog #(.IN_W(16), .SHIFT(2), .CNT_W(8)) u_dut_b (
        .dco_clk   (clk),
        .rst_n     (b_rst_n),
        .fin_w     (b_fin_w),
        .en        (b_en),
        .sync      (b_sync),
        .fout      (b_fout),
        .fout_rise (b_fout_rise),
        .half_act  (b_half_act)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int cy, input int h);
        exp_t e;
        e.cy   = cy;
        e.half = h;
        qa.push_back(e);
    endtask

    // Advance to the falling edge at which cyc equals target.
    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Monitor for unit A.
    always @(negedge clk) begin
        if (fout_rise) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_rise", 32'(cyc), 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk("a_rise_cycle", 32'(cyc), 32'(e.cy));
                chk("a_rise_half", 32'(half_act), 32'(e.half));
                chk("a_rise_fout", 32'(fout), 32'd1);
            end
        end
    end

    // Monitor for unit B.
    always @(negedge clk) begin
        if (b_fout_rise) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_rise", 32'(cyc), 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk("b_rise_cycle", 32'(cyc), 32'(e.cy));
                chk("b_rise_half", 32'(b_half_act), 32'(e.half));
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        b_rst_n = 1'b0;
        fin_w   = 16'd16;
        b_fin_w = 16'hFFFF;
        en      = 1'b0;
        b_en    = 1'b0;
        sync    = 1'b0;
        b_sync  = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_fout", 32'(fout), 32'd0);
        chk("rst_rise", 32'(fout_rise), 32'd0);
        chk("rst_half", 32'(half_act), 32'd0);
        chk("rst_b_half", 32'(b_half_act), 32'd0);

        rst_n   = 1'b1;
        b_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("load_hold_half", 32'(half_act), 32'd0);
        chk("load_hold_fout", 32'(fout), 32'd0);

        // Enable: next rising edge (c+1) is the LOAD cycle.
        c = cyc;
        en   = 1'b1;
        b_en = 1'b1;
        push_a(c + 6, 4);   push_a(c + 16, 4);  push_a(c + 26, 4);
        push_a(c + 42, 10); push_a(c + 64, 10); push_a(c + 93, 10);
        push_a(c + 105, 0); push_a(c + 107, 0); push_a(c + 109, 0);
        push_a(c + 111, 0); push_a(c + 113, 0);
        push_a(c + 125, 4); push_a(c + 135, 4);
        push_a(c + 146, 4); push_a(c + 156, 4);
        begin
            exp_t e;
            e.cy   = c + 257;
            e.half = 255;
            qb.push_back(e);
        end

        wait_cyc(c + 2);
        chk("load_half_a", 32'(half_act), 32'd4);
        chk("load_half_b_sat", 32'(b_half_act), 32'd255);

        // Mid-half-period ratio change: high half still ends at c+31.
        wait_cyc(c + 28);
        fin_w = 16'd40;
        wait_cyc(c + 30);
        chk("chg_high_kept", 32'(fout), 32'd1);
        wait_cyc(c + 31);
        chk("chg_fall", 32'(fout), 32'd0);
        chk("chg_half_new", 32'(half_act), 32'd10);

        // Enable low for 7 cycles starting on a terminal-count cycle.
        wait_cyc(c + 74);
        en = 1'b0;
        wait_cyc(c + 78);
        chk("hold_half", 32'(half_act), 32'd10);
        wait_cyc(c + 81);
        chk("hold_fout", 32'(fout), 32'd1);
        en = 1'b1;
        wait_cyc(c + 82);
        chk("hold_release_fall", 32'(fout), 32'd0);

        // H = 0 via fin_w = 3, then fin_w = 0.
        wait_cyc(c + 94);
        fin_w = 16'd3;
        wait_cyc(c + 106);
        chk("div2_fall", 32'(fout), 32'd0);
        wait_cyc(c + 109);
        fin_w = 16'd0;
        wait_cyc(c + 113);
        fin_w = 16'd16;

        // sync on the terminal-count cycle at edge c+119.
        wait_cyc(c + 118);
        sync = 1'b1;
        wait_cyc(c + 119);
        sync = 1'b0;
        chk("sync_fout", 32'(fout), 32'd0);
        chk("sync_rise", 32'(fout_rise), 32'd0);

        // Asynchronous reset mid-run.
        wait_cyc(c + 138);
        rst_n = 1'b0;
        #1;
        chk("arst_fout", 32'(fout), 32'd0);
        chk("arst_rise", 32'(fout_rise), 32'd0);
        chk("arst_half", 32'(half_act), 32'd0);
        wait_cyc(c + 140);
        rst_n = 1'b1;
        wait_cyc(c + 157);
        en = 1'b0;

        // Saturated unit: low half lasts 256 cycles.
        wait_cyc(c + 256);
        chk("b_low_half", 32'(b_fout), 32'd0);
        wait_cyc(c + 257);
        chk("b_rise_fout", 32'(b_fout), 32'd1);
        wait_cyc(c + 262);

        chk("a_queue_empty", 32'(qa.size()), 32'd0);
        chk("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
